// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the MIPS core control path: the PC sequencer state
// encoding, the PC target-mux select codes and the default fetch timeout.
// Optional feature macro: PCSEQ_INTR_EN adds the INTR state.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_UPDATE = 3'd4,
      ST_HALT   = 3'd5
`ifdef PCSEQ_INTR_EN
      ,
      ST_INTR   = 3'd6
`endif
   } seq_state_t;

   // PC target mux select; code 3 is reserved and never driven.
   localparam logic [1:0] PCSEL_BR  = 2'd0;
   localparam logic [1:0] PCSEL_JMP = 2'd1;
   localparam logic [1:0] PCSEL_VEC = 2'd2;

   // Cycles FETCH waits for mem_ack before faulting (legal 2..255).
   localparam int FETCH_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the sequencer's handshake with instruction memory, the execute unit
// and the PC register.
//   master : the sequencer (drives PC/memory/execute strobes, status)
//   slave  : the surrounding datapath (drives start, acks, decode flags)
// Optional feature macro: PCSEQ_INTR_EN adds int_req, epc_ld and int_ack.
// -----------------------------------------------------------------------------
interface pc_sequencer_if;

   logic       start;
   logic       mem_ack;
   logic       exec_done;
   logic       br_taken;
   logic       jump;
   logic       halt_req;
   logic       pc_inc;
   logic       pc_ld;
   logic [1:0] pc_sel;
   logic       mem_rd;
   logic       ir_ld;
   logic       exec_start;
   logic       halted;
   logic       fault;
`ifdef PCSEQ_INTR_EN
   logic       int_req;
   logic       epc_ld;
   logic       int_ack;
`endif

`ifdef PCSEQ_INTR_EN
   modport master (
      input  start, mem_ack, exec_done, br_taken, jump, halt_req, int_req,
      output pc_inc, pc_ld, pc_sel, mem_rd, ir_ld, exec_start, halted, fault,
             epc_ld, int_ack
   );
   modport slave (
      output start, mem_ack, exec_done, br_taken, jump, halt_req, int_req,
      input  pc_inc, pc_ld, pc_sel, mem_rd, ir_ld, exec_start, halted, fault,
             epc_ld, int_ack
   );
`else
   modport master (
      input  start, mem_ack, exec_done, br_taken, jump, halt_req,
      output pc_inc, pc_ld, pc_sel, mem_rd, ir_ld, exec_start, halted, fault
   );
   modport slave (
      output start, mem_ack, exec_done, br_taken, jump, halt_req,
      input  pc_inc, pc_ld, pc_sel, mem_rd, ir_ld, exec_start, halted, fault
   );
`endif

endinterface

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
// Counts FETCH cycles spent waiting for the instruction memory.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (held while the sequencer is not fetching)
//   enable     : count this cycle (fetching, no ack)
//   tc         : this counting cycle is the LIMIT-th without an ack
// The 8-bit count saturates at 255 and never wraps.
// -----------------------------------------------------------------------------
module fetch_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

   logic [7:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_reg <= 8'd0;
      end else if (enable && (count_reg != 8'hFF)) begin
         count_reg <= count_reg + 8'd1;
      end
   end

   // Fires on the cycle whose increment brings the count to LIMIT, so the
   // sequencer leaves FETCH after exactly LIMIT unacknowledged cycles.
   assign tc = enable && (count_reg >= LIMIT_M1);

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Multicycle PC / instruction-fetch control FSM for the MIPS core:
// IDLE -> FETCH -> DECODE -> EXEC -> UPDATE -> FETCH ..., plus HALT (exits
// only on reset) and, with PCSEQ_INTR_EN, INTR after UPDATE.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pc_sequencer_if.master (start, mem_ack, exec_done, br_taken,
//                jump, halt_req in; pc_inc, pc_ld, pc_sel, mem_rd, ir_ld,
//                exec_start, halted, fault out; int_req/epc_ld/int_ack with
//                PCSEQ_INTR_EN)
// Optional feature macro: PCSEQ_INTR_EN (interrupt entry via INTR state).
// All strobes except ir_ld are registered from the next state, so each one
// is valid for the whole cycle the FSM spends in the corresponding state.
// -----------------------------------------------------------------------------
module pc_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.master bus
);

   seq_state_t state_reg;
   logic       pc_inc_reg;
   logic       pc_ld_reg;
   logic [1:0] pc_sel_reg;
   logic       mem_rd_reg;
   logic       exec_start_reg;
   logic       halted_reg;
   logic       fault_reg;
   logic       halt_flag_reg;
`ifdef PCSEQ_INTR_EN
   logic       pending_reg;
   logic       epc_ld_reg;
   logic       int_ack_reg;
`endif

   logic timer_clear;
   logic timer_en;
   logic timer_tc;

   assign timer_clear = (state_reg != ST_FETCH);
   assign timer_en    = (state_reg == ST_FETCH) && !bus.mem_ack;

   fetch_timer #(
      .LIMIT (FETCH_TIMEOUT)
   ) u_fetch_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .enable (timer_en),
      .tc     (timer_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         pc_inc_reg     <= 1'b0;
         pc_ld_reg      <= 1'b0;
         pc_sel_reg     <= PCSEL_BR;
         mem_rd_reg     <= 1'b0;
         exec_start_reg <= 1'b0;
         halted_reg     <= 1'b0;
         fault_reg      <= 1'b0;
         halt_flag_reg  <= 1'b0;
`ifdef PCSEQ_INTR_EN
         pending_reg    <= 1'b0;
         epc_ld_reg     <= 1'b0;
         int_ack_reg    <= 1'b0;
`endif
      end else begin
         pc_inc_reg     <= 1'b0;
         pc_ld_reg      <= 1'b0;
         pc_sel_reg     <= PCSEL_BR;
         mem_rd_reg     <= 1'b0;
         exec_start_reg <= 1'b0;
         halted_reg     <= 1'b0;
`ifdef PCSEQ_INTR_EN
         epc_ld_reg     <= 1'b0;
         int_ack_reg    <= 1'b0;
         // The request being serviced must not re-arm itself during INTR.
         if ((state_reg != ST_INTR) && bus.int_req) begin
            pending_reg <= 1'b1;
         end
`endif
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  state_reg  <= ST_FETCH;
                  mem_rd_reg <= 1'b1;
               end
            end
            ST_FETCH: begin
               // An ack always wins over a timeout on the same cycle.
               if (bus.mem_ack) begin
                  state_reg      <= ST_DECODE;
                  exec_start_reg <= 1'b1;
               end else if (timer_tc) begin
                  state_reg  <= ST_HALT;
                  halted_reg <= 1'b1;
                  fault_reg  <= 1'b1;
               end else begin
                  mem_rd_reg <= 1'b1;
               end
            end
            ST_DECODE: begin
               state_reg <= ST_EXEC;
            end
            ST_EXEC: begin
               if (bus.exec_done) begin
                  state_reg     <= ST_UPDATE;
                  halt_flag_reg <= bus.halt_req;
                  // The UPDATE strobes themselves hold the captured
                  // jump/branch decision; priority halt > jump > branch.
                  if (bus.halt_req) begin
                     pc_inc_reg <= 1'b0;
                  end else if (bus.jump) begin
                     pc_ld_reg  <= 1'b1;
                     pc_sel_reg <= PCSEL_JMP;
                  end else if (bus.br_taken) begin
                     pc_ld_reg  <= 1'b1;
                     pc_sel_reg <= PCSEL_BR;
                  end else begin
                     pc_inc_reg <= 1'b1;
                  end
               end
            end
            ST_UPDATE: begin
               if (halt_flag_reg) begin
                  state_reg  <= ST_HALT;
                  halted_reg <= 1'b1;
`ifdef PCSEQ_INTR_EN
               end else if (pending_reg) begin
                  // EPC captures the PC just written by this UPDATE.
                  state_reg   <= ST_INTR;
                  epc_ld_reg  <= 1'b1;
                  int_ack_reg <= 1'b1;
                  pc_ld_reg   <= 1'b1;
                  pc_sel_reg  <= PCSEL_VEC;
`endif
               end else begin
                  state_reg  <= ST_FETCH;
                  mem_rd_reg <= 1'b1;
               end
            end
`ifdef PCSEQ_INTR_EN
            ST_INTR: begin
               state_reg   <= ST_FETCH;
               mem_rd_reg  <= 1'b1;
               pending_reg <= 1'b0;
            end
`endif
            ST_HALT: begin
               halted_reg <= 1'b1;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.pc_inc     = pc_inc_reg;
   assign bus.pc_ld      = pc_ld_reg;
   assign bus.pc_sel     = pc_sel_reg;
   assign bus.mem_rd     = mem_rd_reg;
   assign bus.ir_ld      = (state_reg == ST_FETCH) && bus.mem_ack;
   assign bus.exec_start = exec_start_reg;
   assign bus.halted     = halted_reg;
   assign bus.fault      = fault_reg;
`ifdef PCSEQ_INTR_EN
   assign bus.epc_ld     = epc_ld_reg;
   assign bus.int_ack    = int_ack_reg;
`endif

endmodule
